weight_bram_arbiter: RTL and testbench
======================================

# weight_bram_arbiter

Shares the single-port weight BRAM between two requesters: the AXI-stream weight fill path (writes) and the convolution control unit's weight fetch path (reads). Owns the BRAM write and read address counters, arbitrates one access per cycle, registers the BRAM command, and regenerates the read-data valid strobe after the fixed BRAM latency. Sits between the AXI slave input, the control unit, and the weight BRAM primitive.

## Interface
- BRAM_ADDRESS_WIDTH, 12, BRAM address width; depth is 2^BRAM_ADDRESS_WIDTH words.
- DATA_WIDTH, 32, BRAM word width.
- READ_LATENCY, 2, BRAM read latency in cycles (1..4).

- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_valid  in  1  fill word available.
- wr_ready  out  1  fill word accepted this cycle.
- wr_data  in  DATA_WIDTH  fill word.
- wr_last  in  1  final word of a weight set.
- wr_done  out  1  one-cycle pulse after the wr_last word is accepted.
- rd_req  in  1  fetch request; held high until rd_ack.
- rd_step  in  2  address increment after a granted fetch (1 or 2; 0 treated as 1, 3 as 2).
- address_reset  in  1  set read address to 0.
- rd_ack  out  1  fetch granted this cycle.
- rd_valid  out  1  rd_data valid (one cycle per granted fetch).
- rd_data  out  DATA_WIDTH  fetched word.
- bram_en  out  1  BRAM enable.
- bram_we  out  1  BRAM write enable.
- bram_addr  out  BRAM_ADDRESS_WIDTH  BRAM address.
- bram_wdata  out  DATA_WIDTH  BRAM write data.
- bram_rdata  in  DATA_WIDTH  BRAM read data.

## Operation
- Reset values: wr_ready 0, wr_done 0, rd_ack 0, rd_valid 0, rd_data 0, bram_en 0, bram_we 0, bram_addr 0, bram_wdata 0; write and read address counters 0; last-grant flag = write.
- Arbiter states: IDLE (no request), GNT_WR, GNT_RD; evaluated every cycle combinationally from wr_valid, rd_req, priority rule; exactly one grant per cycle.
- Single requester: that requester is granted.
- Both requesting: priority per Configuration.
- Write grant: wr_ready=1; next cycle bram_en=1, bram_we=1, bram_addr=write address, bram_wdata=wr_data. Write address +1, wraps 2^AW-1 -> 0. If wr_last, write address -> 0 and wr_done pulses the following cycle.
- Read grant: rd_ack=1; next cycle bram_en=1, bram_we=0, bram_addr=read address. Read address += step, modulo 2^AW.
- address_reset: read address forced to 0. If coincident with a read grant, the granted fetch uses address 0 and the counter becomes step.
- Read pipeline: shift register of READ_LATENCY+1 valid bits; rd_data captured from bram_rdata when the tap reaches the end; rd_valid and rd_data register together. No backpressure: consumer must accept every rd_valid.
- No grant cycle: bram_en=0, bram_we=0; bram_addr and bram_wdata hold.
- Reset mid-operation: in-flight reads discarded, no rd_valid after rst_n deasserts; counters to 0.

## Timing
- rd_ack / wr_ready combinational in request cycle T.
- BRAM command at T+1 (registered).
- rd_valid/rd_data at T+2+READ_LATENCY (default: T+4).
- wr_done at T+1 of the wr_last handshake.
- Back-to-back grants sustain one access per cycle; reads pipelined, up to READ_LATENCY+1 in flight.

## Configuration
- WEIGHT_ARB_ROUND_ROBIN_EN defined: on contention, grant the requester not granted last (last-grant flag updates on every grant). Alternating read/write under continuous contention.
- Undefined: fixed priority, reads always win; writes granted only when rd_req=0.

## Test plan
- Reset: after rst_n release all outputs 0; first write (wr_data=0xA5A5A5A5) lands at bram_addr=0 with bram_we=1 one cycle after wr_ready.
- Fill 4 words, wr_last on 4th -> bram_addr 0,1,2,3; wr_done pulses once one cycle after 4th handshake; next write at address 0.
- Read, rd_step=2, 3 fetches after address_reset -> bram_addr 0,2,4; rd_valid exactly 4 cycles after each rd_ack, data matches BRAM model.
- Continuous contention: with WEIGHT_ARB_ROUND_ROBIN_EN grants alternate RD,WR,RD,WR (first grant to read); without it, 10 cycles all reads, wr_ready stays 0.
- Wrap: read address 0xFFF, rd_step=2 -> fetch at 0xFFF, next at 0x001; write at 0xFFF then 0x000.
- rst_n asserted with 2 reads in flight -> no rd_valid afterwards; address_reset coincident with grant -> fetch at address 0.

Source files
------------

// File: rtl/weight_bram_arbiter.sv
// Single-port weight BRAM arbiter: fill writes vs. conv fetch reads, one access per cycle.
// Define WEIGHT_ARB_ROUND_ROBIN_EN for round-robin on contention; default gives reads fixed priority.
module weight_bram_arbiter #(
    parameter int BRAM_ADDRESS_WIDTH = 12,
    parameter int DATA_WIDTH         = 32,
    parameter int READ_LATENCY       = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_valid_i,
    output logic                          wr_ready_o,
    input  logic [DATA_WIDTH-1:0]         wr_data_i,
    input  logic                          wr_last_i,
    output logic                          wr_done_o,
    input  logic                          rd_req_i,
    input  logic [1:0]                    rd_step_i,
    input  logic                          address_reset_i,
    output logic                          rd_ack_o,
    output logic                          rd_valid_o,
    output logic [DATA_WIDTH-1:0]         rd_data_o,
    output logic                          bram_en_o,
    output logic                          bram_we_o,
    output logic [BRAM_ADDRESS_WIDTH-1:0] bram_addr_o,
    output logic [DATA_WIDTH-1:0]         bram_wdata_o,
    input  logic [DATA_WIDTH-1:0]         bram_rdata_i
);

    localparam int AW = BRAM_ADDRESS_WIDTH;
    localparam logic [AW-1:0] ONE = AW'(1);
    localparam logic [AW-1:0] TWO = AW'(2);

    // Encoding chosen so bit 0 is the BRAM enable and bit 1 the write enable.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GNT_RD = 2'b01,
        GNT_WR = 2'b11
    } gnt_e;

    gnt_e                  state_d, state_q;
    logic                  last_rd_d, last_rd_q;
    logic [AW-1:0]         wr_addr_d, wr_addr_q;
    logic [AW-1:0]         rd_addr_d, rd_addr_q;
    logic [AW-1:0]         addr_d, addr_q;
    logic [DATA_WIDTH-1:0] wdata_d, wdata_q;
    logic [AW-1:0]         fetch_addr;
    logic [AW-1:0]         step;
    logic                  rd_wins;
    logic                  wr_done_q;
    logic [READ_LATENCY:0] vld_q;
    logic                  rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_comb begin
        state_d    = IDLE;
        last_rd_d  = last_rd_q;
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        step       = (rd_step_i >= 2'd2) ? TWO : ONE;
        fetch_addr = address_reset_i ? '0 : rd_addr_q;
`ifdef WEIGHT_ARB_ROUND_ROBIN_EN
        rd_wins    = rd_req_i && !(wr_valid_i && last_rd_q);
`else
        rd_wins    = rd_req_i;
`endif
        if (rd_wins) begin
            state_d = GNT_RD;
        end else if (wr_valid_i) begin
            state_d = GNT_WR;
        end

        if (address_reset_i) begin
            rd_addr_d = '0;
        end

        case (state_d)
            GNT_RD: begin
                addr_d    = fetch_addr;
                rd_addr_d = fetch_addr + step;
                last_rd_d = 1'b1;
            end
            GNT_WR: begin
                addr_d    = wr_addr_q;
                wdata_d   = wr_data_i;
                wr_addr_d = wr_last_i ? '0 : wr_addr_q + ONE;
                last_rd_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_rd_q <= 1'b0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_rd_q <= last_rd_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wr_done_q <= (state_d == GNT_WR) && wr_last_i;
        end
    end

    // Valid tap tracks each fetch through the command register and BRAM latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            vld_q      <= {vld_q[READ_LATENCY-1:0], (state_d == GNT_RD)};
            rd_valid_q <= vld_q[READ_LATENCY];
            if (vld_q[READ_LATENCY]) begin
                rd_data_q <= bram_rdata_i;
            end
        end
    end

    assign wr_ready_o   = (state_d == GNT_WR);
    assign rd_ack_o     = (state_d == GNT_RD);
    assign wr_done_o    = wr_done_q;
    assign rd_valid_o   = rd_valid_q;
    assign rd_data_o    = rd_data_q;
    assign bram_en_o    = state_q[0];
    assign bram_we_o    = state_q[1];
    assign bram_addr_o  = addr_q;
    assign bram_wdata_o = wdata_q;

endmodule

// File: tb/tb_weight_bram_arbiter.sv
// Scoreboard bench for weight_bram_arbiter with a behavioural single-port BRAM of fixed latency.
module tb_weight_bram_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int RL = 2;
`ifdef WEIGHT_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk, rst_n;
    logic          wr_valid, wr_ready, wr_last, wr_done;
    logic [DW-1:0] wr_data;
    logic          rd_req, address_reset, rd_ack, rd_valid;
    logic [1:0]    rd_step;
    logic [DW-1:0] rd_data;
    logic          bram_en, bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_wdata, bram_rdata;

    weight_bram_arbiter #(
        .BRAM_ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data),
        .wr_last_i(wr_last), .wr_done_o(wr_done),
        .rd_req_i(rd_req), .rd_step_i(rd_step), .address_reset_i(address_reset),
        .rd_ack_o(rd_ack), .rd_valid_o(rd_valid), .rd_data_o(rd_data),
        .bram_en_o(bram_en), .bram_we_o(bram_we), .bram_addr_o(bram_addr),
        .bram_wdata_o(bram_wdata), .bram_rdata_i(bram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural BRAM: read-first, READ_LATENCY cycles from command to data.
    logic [DW-1:0] mem    [0:(1<<AW)-1];
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    logic [DW-1:0] rpipe  [0:RL-1];
    always @(posedge clk) begin
        if (bram_en && bram_we) mem[bram_addr] <= bram_wdata;
        rpipe[0] <= mem[bram_addr];
        for (int k = 1; k < RL; k++) rpipe[k] <= rpipe[k-1];
    end
    assign bram_rdata = rpipe[RL-1];

    typedef struct { int due; logic we; logic [AW-1:0] addr; logic [DW-1:0] data; } cmd_t;
    typedef struct { int due; logic [DW-1:0] data; } rd_t;
    cmd_t          cmdq[$];
    rd_t           rdq[$];
    int            doneq[$];
    logic [AW:0]   cmd_log[$];
    int            gnt_hist[$];
    int            done_cnt, rdv_cnt;
    int            total = 0;
    int            bad = 0;
    logic [AW-1:0] m_wr, m_rd;
    logic          m_last_rd;

    // Scoreboard: pops expected BRAM commands, wr_done pulses and read returns by due cycle.
    logic exp_en, exp_done, exp_v;
    cmd_t c;
    rd_t  r;
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bram_en === 1'b1) cmd_log.push_back({bram_we, bram_addr});
            exp_en = (cmdq.size() > 0) && (cmdq[0].due == cyc);
            total++;
            if (bram_en !== exp_en) begin
                bad++;
                $display("FAIL bram_en cyc=%0d: got %b, required %b", cyc, bram_en, exp_en);
            end
            if (exp_en) begin
                c = cmdq.pop_front();
                total++;
                if (bram_we !== c.we || bram_addr !== c.addr || (c.we && bram_wdata !== c.data)) begin
                    bad++;
                    $display("FAIL bram_cmd cyc=%0d: got we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                             cyc, bram_we, bram_addr, bram_wdata, c.we, c.addr, c.data);
                end
            end
            exp_done = (doneq.size() > 0) && (doneq[0] == cyc);
            if (exp_done) void'(doneq.pop_front());
            if (wr_done === 1'b1) done_cnt++;
            total++;
            if (wr_done !== exp_done) begin
                bad++;
                $display("FAIL wr_done cyc=%0d: got %b, required %b", cyc, wr_done, exp_done);
            end
            exp_v = (rdq.size() > 0) && (rdq[0].due == cyc);
            if (rd_valid === 1'b1) rdv_cnt++;
            total++;
            if (rd_valid !== exp_v) begin
                bad++;
                $display("FAIL rd_valid cyc=%0d: got %b, required %b", cyc, rd_valid, exp_v);
            end
            if (exp_v) begin
                r = rdq.pop_front();
                total++;
                if (rd_data !== r.data) begin
                    bad++;
                    $display("FAIL rd_data cyc=%0d: got %h, required %h", cyc, rd_data, r.data);
                end
            end
        end
    end

    task automatic drive(input logic wv, input logic [DW-1:0] wd, input logic wl,
                         input logic rr, input logic [1:0] st, input logic ar);
        logic          er, ew;
        logic [AW-1:0] a;
        wr_valid = wv; wr_data = wd; wr_last = wl;
        rd_req = rr; rd_step = st; address_reset = ar;
        @(negedge clk);
        er = rr && !(wv && RR && m_last_rd);
        ew = wv && !er;
        total++;
        if (rd_ack !== er || wr_ready !== ew) begin
            bad++;
            $display("FAIL grant cyc=%0d: got rd_ack=%b wr_ready=%b, required rd_ack=%b wr_ready=%b",
                     cyc, rd_ack, wr_ready, er, ew);
        end
        if (ew) begin
            cmdq.push_back('{cyc + 1, 1'b1, m_wr, wd});
            shadow[m_wr] = wd;
            if (wl) begin
                doneq.push_back(cyc + 1);
                m_wr = '0;
            end else begin
                m_wr = m_wr + 12'd1;
            end
            m_last_rd = 1'b0;
        end else if (er) begin
            a = ar ? 12'd0 : m_rd;
            cmdq.push_back('{cyc + 1, 1'b0, a, '0});
            rdq.push_back('{cyc + 2 + RL, shadow[a]});
            m_rd = a + ((st >= 2'd2) ? 12'd2 : 12'd1);
            m_last_rd = 1'b1;
        end
        if (!er && ar) m_rd = '0;
        gnt_hist.push_back(er ? 2 : (ew ? 1 : 0));
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        wr_valid = 0; wr_data = '0; wr_last = 0; rd_req = 0; rd_step = 0; address_reset = 0;
        m_wr = '0; m_rd = '0; m_last_rd = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({wr_ready, wr_done, rd_ack, rd_valid, bram_en, bram_we} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b, required 000000",
                     {wr_ready, wr_done, rd_ack, rd_valid, bram_en, bram_we});
        end
        total++;
        if (rd_data !== '0 || bram_addr !== '0 || bram_wdata !== '0) begin
            bad++;
            $display("FAIL reset_data: got rd_data=%h addr=%h wdata=%h, required 0", rd_data, bram_addr, bram_wdata);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);
        cmd_log.delete();
        drive(1'b1, 32'hA5A5_A5A5, 1'b1, 1'b0, 2'd0, 1'b0);
        idle(2);
        total++;
        if (cmd_log.size() != 1 || cmd_log[0] !== {1'b1, 12'h000}) begin
            bad++;
            $display("FAIL first_write: got %0d cmds first=%h, required 1 cmd we=1 addr=000",
                     cmd_log.size(), (cmd_log.size() > 0) ? cmd_log[0] : 13'h0);
        end
    endtask

    task automatic test_fill;
        logic [AW:0] exp_log [0:4];
        exp_log[0] = {1'b1, 12'h000}; exp_log[1] = {1'b1, 12'h001}; exp_log[2] = {1'b1, 12'h002};
        exp_log[3] = {1'b1, 12'h003}; exp_log[4] = {1'b1, 12'h000};
        cmd_log.delete(); done_cnt = 0;
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h1111_0000 + i, (i == 3), 1'b0, 2'd0, 1'b0);
        drive(1'b1, 32'h2222_0000, 1'b0, 1'b0, 2'd0, 1'b0);
        idle(3);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (cmd_log.size() != 5 || cmd_log[i] !== exp_log[i]) begin
                bad++;
                $display("FAIL fill_addr[%0d]: got %h (n=%0d), required %h", i,
                         (cmd_log.size() > i) ? cmd_log[i] : 13'h0, cmd_log.size(), exp_log[i]);
            end
        end
        total++;
        if (done_cnt != 1) begin
            bad++;
            $display("FAIL fill_done_count: got %0d, required 1", done_cnt);
        end
    endtask

    task automatic test_read_step;
        cmd_log.delete(); rdv_cnt = 0;
        drive(1'b0, '0, 1'b0, 1'b1, 2'd2, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1, 2'd2, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b1, 2'd3, 1'b0);
        idle(6);
        total++;
        if (cmd_log.size() != 3 || cmd_log[0] !== 13'h000 || cmd_log[1] !== 13'h002 || cmd_log[2] !== 13'h004) begin
            bad++;
            $display("FAIL read_step_addrs: got n=%0d, required reads at 000,002,004", cmd_log.size());
        end
        total++;
        if (rdv_cnt != 3) begin
            bad++;
            $display("FAIL read_valid_count: got %0d, required 3", rdv_cnt);
        end
    endtask

    task automatic test_contention;
        int exp_g;
        drive(1'b1, 32'h3333_0000, 1'b0, 1'b0, 2'd0, 1'b0);
        gnt_hist.delete();
        for (int i = 0; i < 10; i++) drive(1'b1, 32'h4444_0000 + i, 1'b0, 1'b1, 2'd1, 1'b0);
        idle(6);
        for (int i = 0; i < 10; i++) begin
            exp_g = (RR && (i % 2 == 1)) ? 1 : 2;
            total++;
            if (gnt_hist[i] != exp_g) begin
                bad++;
                $display("FAIL contention[%0d]: got grant %0d, required %0d (1=wr 2=rd)", i, gnt_hist[i], exp_g);
            end
        end
    endtask

    task automatic test_wrap;
        drive(1'b0, '0, 1'b0, 1'b1, 2'd2, 1'b1);
        for (int i = 1; i < 2047; i++) drive(1'b0, '0, 1'b0, 1'b1, 2'd2, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b1, 2'd1, 1'b0);
        idle(1);
        cmd_log.delete();
        drive(1'b0, '0, 1'b0, 1'b1, 2'd2, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b1, 2'd0, 1'b0);
        idle(6);
        total++;
        if (cmd_log.size() != 2 || cmd_log[0] !== 13'h0FFF || cmd_log[1] !== 13'h0001) begin
            bad++;
            $display("FAIL read_wrap: got n=%0d first=%h, required reads at FFF then 001",
                     cmd_log.size(), (cmd_log.size() > 0) ? cmd_log[0] : 13'h0);
        end
        drive(1'b1, 32'h5555_0000, 1'b1, 1'b0, 2'd0, 1'b0);
        for (int i = 0; i < 4095; i++) drive(1'b1, 32'h6000_0000 + i, 1'b0, 1'b0, 2'd0, 1'b0);
        idle(1);
        cmd_log.delete();
        drive(1'b1, 32'h7777_0FFF, 1'b0, 1'b0, 2'd0, 1'b0);
        drive(1'b1, 32'h7777_0000, 1'b0, 1'b0, 2'd0, 1'b0);
        idle(2);
        total++;
        if (cmd_log.size() != 2 || cmd_log[0] !== 13'h1FFF || cmd_log[1] !== 13'h1000) begin
            bad++;
            $display("FAIL write_wrap: got n=%0d first=%h, required writes at FFF then 000",
                     cmd_log.size(), (cmd_log.size() > 0) ? cmd_log[0] : 13'h0);
        end
    endtask

    task automatic test_reset_midop;
        drive(1'b0, '0, 1'b0, 1'b1, 2'd1, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1, 2'd1, 1'b0);
        wr_valid = 0; rd_req = 0; address_reset = 0;
        rst_n = 1'b0;
        cmdq.delete(); rdq.delete(); doneq.delete();
        m_wr = '0; m_rd = '0; m_last_rd = 1'b0;
        rdv_cnt = 0;
        repeat (2) begin
            @(negedge clk);
            total++;
            if (rd_valid !== 1'b0) begin
                bad++;
                $display("FAIL reset_midop_valid: got %b during reset, required 0", rd_valid);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(8);
        total++;
        if (rdv_cnt != 0) begin
            bad++;
            $display("FAIL reset_midop_discard: got %0d rd_valid after reset, required 0", rdv_cnt);
        end
        cmd_log.delete();
        drive(1'b0, '0, 1'b0, 1'b1, 2'd1, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b1, 2'd1, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b1, 2'd2, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1, 2'd2, 1'b0);
        idle(6);
        total++;
        if (cmd_log.size() != 4 || cmd_log[0] !== 13'h000 || cmd_log[1] !== 13'h001 ||
            cmd_log[2] !== 13'h000 || cmd_log[3] !== 13'h002) begin
            bad++;
            $display("FAIL addr_reset_coincident: got n=%0d, required reads at 000,001,000,002", cmd_log.size());
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]    = 32'hC0DE_0000 | i;
            shadow[i] = 32'hC0DE_0000 | i;
        end
        test_reset();
        test_fill();
        test_read_step();
        test_contention();
        test_wrap();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before completion, required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
